spi_note_cmd_rx: RTL
====================

// Module: spi_note_cmd_rx
// PURPOSE
//  SPI-slave command receiver feeding voice_controller's i_SPI_* inputs. Oversamples an external
//  SPI mode-0 link in the i_clk domain, assembles 56-bit command frames and decodes them.
//  Emits one-cycle flag_dds / flag_adsr strobes with voice index, tuning code, velocity, note status.
//  Sits between the MCU SPI pins and voice_controller.
// PARAMETERS
//  SYNC_STAGES  2      flip-flop synchroniser depth on SCK, CS_N, MOSI (>=2)
//  NUM_VOICES   256    voice indices >= NUM_VOICES are rejected
//  OP_NOTE_ON   8'h90  opcode: note on
//  OP_NOTE_OFF  8'h80  opcode: note off
//  OP_RETUNE    8'hA0  opcode: retune held voice
// PORTS
//  i_clk             in   1   system clock
//  i_reset           in   1   asynchronous, active-high reset
//  i_spi_sck         in   1   SPI clock, async, idle low, sample on rising edge
//  i_spi_cs_n        in   1   SPI chip select, async, active low
//  i_spi_mosi        in   1   SPI data, MSB first
//  o_SPI_note_status out  1   1 = note on, 0 = note off
//  o_SPI_voice_index out  8   target voice
//  o_SPI_tuning_code out  32  DDS phase increment
//  o_SPI_velocity    out  7   note velocity
//  o_SPI_flag_dds    out  1   one-cycle strobe: DDS update
//  o_SPI_flag_adsr   out  1   one-cycle strobe: ADSR gate update
//  o_err_count       out  8   rejected-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, bit counter 0, shift register 0, state IDLE. Synchroniser flops reset to SCK=0, CS_N=1.
//  Frame, MSB first, 56 bits: [55:48] opcode, [47:40] voice, [39:8] tuning, [7] ignored, [6:0] velocity.
//  SCK edge = synced SCK 0->1. CS fall/rise = synced CS_N 1->0 / 0->1. SCK <= i_clk/8 required.
//  FSM: IDLE -(CS fall)-> SHIFT. SHIFT: each SCK edge shifts synced MOSI in, count+1.
//   SHIFT, count reaches 56 -> DECODE, 1 cycle -> HOLD. HOLD ignores SCK; HOLD -(CS rise)-> IDLE.
//   SHIFT -(CS rise, count<56)-> IDLE: abort, frame discarded, error counted. No outputs change.
//  Reset released while CS_N low: stay IDLE until a CS rise and the next CS fall. No partial frame is accepted.
//  SCK edge and CS rise in the same cycle: CS rise wins. The bit is dropped and the frame aborts if count<56.
//  DECODE, with voice < NUM_VOICES:
//   OP_NOTE_ON : note_status=1; voice, tuning, velocity latched; flag_dds=1 and flag_adsr=1.
//   OP_NOTE_OFF: note_status=0; voice, velocity latched; tuning unchanged; flag_adsr=1 only.
//   OP_RETUNE  : voice, tuning latched; note_status, velocity unchanged; flag_dds=1 only.
//   other opcode, or voice >= NUM_VOICES: nothing latched, no strobe, error counted.
//  Strobes are high for exactly the cycle after DECODE. Data outputs change in that same cycle and hold until the next accepted frame.
//  Latency: 56th SCK pin edge to strobe = SYNC_STAGES + 2 i_clk cycles.
//  Extra SCK edges after bit 56 (in HOLD) are ignored. One command per CS_N assertion.
// CONFIGURATION
//  SPI_RX_ERR_COUNT_EN defined: o_err_count increments by 1 on each abort or rejected frame.
//   It saturates at 8'hFF and clears only on i_reset.
//  SPI_RX_ERR_COUNT_EN undefined: no counter logic; o_err_count tied to 8'h00.
// TESTING
//  1. Frame 90_05_00A3D70A_7F -> 1 cycle with flag_dds=flag_adsr=1; status=1, voice=8'h05,
//     tuning=32'h00A3D70A, velocity=7'h7F; strobe SYNC_STAGES+2 cycles after 56th SCK edge.
//  2. Then 80_05_FFFFFFFF_40 -> flag_adsr only; status=0, velocity=7'h40, tuning still 32'h00A3D70A.
//  3. A0_05_01234567_00 -> flag_dds only; tuning=32'h01234567; status=0 and velocity=7'h40 unchanged.
//  4. CS_N high after 30 bits, then opcode 8'h55 frame -> no strobes, outputs unchanged;
//     err_count=2 with SPI_RX_ERR_COUNT_EN, 0 without it.
//  5. i_reset pulsed mid-frame with CS_N still low, 30 more bits clocked -> no strobe.
//     After a CS rise, a valid frame is accepted.
//  6. 64 SCK edges in one CS_N window with valid first 56 bits -> exactly one strobe; trailing 8 bits ignored.

Source files
------------

// File: rtl/spi_note_cmd_rx_if.sv
// rtl/spi_note_cmd_rx_if.sv - SPI pin and decoded-command bundle for spi_note_cmd_rx
interface spi_note_cmd_rx_if;
  logic        i_spi_sck;
  logic        i_spi_cs_n;
  logic        i_spi_mosi;
  logic        o_SPI_note_status;
  logic [7:0]  o_SPI_voice_index;
  logic [31:0] o_SPI_tuning_code;
  logic [6:0]  o_SPI_velocity;
  logic        o_SPI_flag_dds;
  logic        o_SPI_flag_adsr;
  logic [7:0]  o_err_count;

  modport slave (
    input  i_spi_sck, i_spi_cs_n, i_spi_mosi,
    output o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code,
           o_SPI_velocity, o_SPI_flag_dds, o_SPI_flag_adsr, o_err_count
  );

  modport master (
    output i_spi_sck, i_spi_cs_n, i_spi_mosi,
    input  o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code,
           o_SPI_velocity, o_SPI_flag_dds, o_SPI_flag_adsr, o_err_count
  );
endinterface

// File: rtl/spi_note_cmd_rx.sv
// rtl/spi_note_cmd_rx.sv - oversampling SPI mode-0 slave decoding 56-bit note commands
// Optional rejected-frame counter enabled by SPI_RX_ERR_COUNT_EN.
module spi_note_cmd_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_VOICES  = 256,
  parameter logic [7:0] OP_NOTE_ON  = 8'h90,
  parameter logic [7:0] OP_NOTE_OFF = 8'h80,
  parameter logic [7:0] OP_RETUNE   = 8'hA0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  spi_note_cmd_rx_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE, S_HOLD} state_t;

  localparam int BOOT_N = SYNC_STAGES + 1;
  localparam int BOOT_W = $clog2(BOOT_N + 1);

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_prev, r_cs_prev;
  logic                   w_sck_s, w_cs_s, w_mosi_s;
  logic                   w_sck_rise, w_cs_rise, w_cs_fall;

  logic [BOOT_W-1:0]      r_boot;
  logic                   w_boot_done;
  logic                   r_armed;

  logic [5:0]             r_count;
  logic [55:0]            r_shift;

  logic [7:0]             w_opcode, w_voice;
  logic [31:0]            w_tuning;
  logic [6:0]             w_velocity;
  logic                   w_is_on, w_is_off, w_is_retune, w_voice_ok, w_accept;

  logic                   r_note_status, r_flag_dds, r_flag_adsr;
  logic [7:0]             r_voice_index;
  logic [31:0]            r_tuning_code;
  logic [6:0]             r_velocity;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.i_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_spi_mosi};
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs_s & r_cs_prev;

  // The synchroniser resets to CS_N=1, so a pin already low at reset release would look
  // like a fresh CS fall. Only arm once the pipeline has flushed and shows CS_N high.
  assign w_boot_done = (r_boot == BOOT_W'(BOOT_N));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_boot  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (!w_boot_done) r_boot <= r_boot + 1'b1;
      if (w_boot_done && w_cs_s) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall && r_armed) w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_cs_rise)                          w_state_next = S_IDLE;
        else if (w_sck_rise && r_count == 6'd55) w_state_next = S_DECODE;
      end
      S_DECODE: w_state_next = w_cs_rise ? S_IDLE : S_HOLD;
      S_HOLD:   if (w_cs_rise) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_shift <= '0;
    end else if (r_state == S_IDLE && w_state_next == S_SHIFT) begin
      r_count <= '0;
    end else if (r_state == S_SHIFT && !w_cs_rise && w_sck_rise) begin
      r_shift <= {r_shift[54:0], w_mosi_s};
      r_count <= r_count + 6'd1;
    end
  end

  assign w_opcode    = r_shift[55:48];
  assign w_voice     = r_shift[47:40];
  assign w_tuning    = r_shift[39:8];
  assign w_velocity  = r_shift[6:0];
  assign w_is_on     = (w_opcode == OP_NOTE_ON);
  assign w_is_off    = (w_opcode == OP_NOTE_OFF);
  assign w_is_retune = (w_opcode == OP_RETUNE);
  assign w_voice_ok  = (int'(w_voice) < NUM_VOICES);
  assign w_accept    = w_voice_ok && (w_is_on || w_is_off || w_is_retune);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_note_status <= 1'b0;
      r_voice_index <= '0;
      r_tuning_code <= '0;
      r_velocity    <= '0;
      r_flag_dds    <= 1'b0;
      r_flag_adsr   <= 1'b0;
    end else begin
      r_flag_dds  <= 1'b0;
      r_flag_adsr <= 1'b0;
      if (r_state == S_DECODE && w_accept) begin
        r_voice_index <= w_voice;
        if (w_is_on) begin
          r_note_status <= 1'b1;
          r_tuning_code <= w_tuning;
          r_velocity    <= w_velocity;
          r_flag_dds    <= 1'b1;
          r_flag_adsr   <= 1'b1;
        end else if (w_is_off) begin
          r_note_status <= 1'b0;
          r_velocity    <= w_velocity;
          r_flag_adsr   <= 1'b1;
        end else begin
          r_tuning_code <= w_tuning;
          r_flag_dds    <= 1'b1;
        end
      end
    end
  end

  assign bus.o_SPI_note_status = r_note_status;
  assign bus.o_SPI_voice_index = r_voice_index;
  assign bus.o_SPI_tuning_code = r_tuning_code;
  assign bus.o_SPI_velocity    = r_velocity;
  assign bus.o_SPI_flag_dds    = r_flag_dds;
  assign bus.o_SPI_flag_adsr   = r_flag_adsr;

`ifdef SPI_RX_ERR_COUNT_EN
  logic       w_err_evt;
  logic [7:0] r_err_count;

  assign w_err_evt = (r_state == S_SHIFT && w_cs_rise) || (r_state == S_DECODE && !w_accept);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                r_err_count <= '0;
    else if (w_err_evt && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end

  assign bus.o_err_count = r_err_count;
`else
  assign bus.o_err_count = 8'h00;
`endif

endmodule
